// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned NUM_SETS    = 8;
  localparam int unsigned BLOCK_BYTES = 4;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned IDX_W       = $clog2(NUM_SETS);
  localparam int unsigned OFF_W       = $clog2(BLOCK_BYTES);
  localparam int unsigned TAG_W       = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned MEM_ADDR_W  = TAG_W + IDX_W;
  localparam int unsigned BLOCK_W     = BLOCK_BYTES * DATA_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } state_e;

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [MEM_ADDR_W-1:0] addr;
    logic [BLOCK_W-1:0]    wdata;
  } mem_req_t;

  function automatic logic [DATA_W-1:0] line_byte(input logic [BLOCK_W-1:0] line,
                                                  input logic [OFF_W-1:0]   off);
    return line[32'(off) * DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: async read of one set, posedge byte or whole-line write.
module dcache_array
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   idx,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [BLOCK_W-1:0] line_o,
  input  logic               byte_we,
  input  logic [OFF_W-1:0]   byte_off,
  input  logic [DATA_W-1:0]  byte_data,
  input  logic               fill_we,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_line
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [TAG_W-1:0]    tag_d  [NUM_SETS];
  logic [BLOCK_W-1:0]  data_q [NUM_SETS];
  logic [BLOCK_W-1:0]  data_d [NUM_SETS];

  assign valid_o = valid_q[idx];
  assign dirty_o = dirty_q[idx];
  assign tag_o   = tag_q[idx];
  assign line_o  = data_q[idx];

  // A refill replaces the whole line and leaves it clean; a store dirties it.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_we) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      tag_d[idx]   = fill_tag;
      data_d[idx]  = fill_line;
    end else if (byte_we) begin
      dirty_d[idx] = 1'b1;
      data_d[idx][32'(byte_off) * DATA_W +: DATA_W] = byte_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: hit logic, miss FSM and
// registered memory-side request.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [DATA_W-1:0]     WRITEDATA,
  output logic [DATA_W-1:0]     READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  logic [TAG_W-1:0]   cpu_tag;
  logic [IDX_W-1:0]   cpu_idx;
  logic [OFF_W-1:0]   cpu_off;
  state_e             state_q, state_d;
  mem_req_t           mem_req_q, mem_req_d;
  logic [BLOCK_W-1:0] refill_q, refill_d;
  logic               arr_valid, arr_dirty;
  logic [TAG_W-1:0]   arr_tag;
  logic [BLOCK_W-1:0] arr_line;
  logic               hit, req, byte_we, fill_we;

  assign {cpu_tag, cpu_idx, cpu_off} = ADDRESS;

  dcache_array u_array (
    .clk       (CLK),
    .rst_n     (RESET),
    .idx       (cpu_idx),
    .valid_o   (arr_valid),
    .dirty_o   (arr_dirty),
    .tag_o     (arr_tag),
    .line_o    (arr_line),
    .byte_we   (byte_we),
    .byte_off  (cpu_off),
    .byte_data (WRITEDATA),
    .fill_we   (fill_we),
    .fill_tag  (cpu_tag),
    .fill_line (refill_q)
  );

  assign hit = arr_valid && (arr_tag == cpu_tag);
  assign req = READ || WRITE;

  always_comb begin
    state_d   = state_q;
    mem_req_d = '0;
    refill_d  = refill_q;
    byte_we   = 1'b0;
    fill_we   = 1'b0;
    case (state_q)
      IDLE: begin
        byte_we = WRITE && hit;
        if (req && !hit) state_d = arr_dirty ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        if (!MEM_BUSYWAIT) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (!MEM_BUSYWAIT) begin
          state_d  = UPDATE;
          refill_d = MEM_READDATA;
        end
      end
      UPDATE: begin
        fill_we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Memory request is derived from the state being entered so it is registered and stable.
    case (state_d)
      WRITEBACK: begin
        mem_req_d.wr    = 1'b1;
        mem_req_d.addr  = {arr_tag, cpu_idx};
        mem_req_d.wdata = arr_line;
      end
      ALLOCATE: begin
        mem_req_d.rd   = 1'b1;
        mem_req_d.addr = {cpu_tag, cpu_idx};
      end
      default: mem_req_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      mem_req_q <= '0;
      refill_q  <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      refill_q  <= refill_d;
    end
  end

  assign MEM_READ      = mem_req_q.rd;
  assign MEM_WRITE     = mem_req_q.wr;
  assign MEM_ADDRESS   = mem_req_q.addr;
  assign MEM_WRITEDATA = mem_req_q.wdata;

  // Stall and load data are combinational so hits complete with zero wait cycles.
  assign BUSYWAIT = RESET && ((state_q != IDLE) || (req && !hit));
  assign READDATA = (state_q == IDLE && READ && !WRITE && hit) ?
                    line_byte(arr_line, cpu_off) : '0;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: flat byte-memory reference plus set-state model, driven by
// directed scenarios and random traffic against a fixed-latency block memory.
module tb_dcache_ctrl;

  localparam int LMEM = 5;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = '0;
  logic [7:0]  WRITEDATA = '0;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA = '0;
  logic        MEM_BUSYWAIT = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem  [64];
  logic [7:0]  gold [256];
  logic [2:0]  m_tag [8];
  bit          m_vld [8];
  bit          m_dty [8];

  dcache_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  initial forever #5 CLK = ~CLK;

  // Block memory: each request stays busy so the controller spends LMEM cycles in that state.
  initial begin
    int       mcnt;
    logic [1:0] mprev;
    mcnt  = 0;
    mprev = 2'b00;
    for (int b = 0; b < 64; b++) mem[b] = $urandom;
    forever begin
      @(negedge CLK);
      if (!MEM_READ && !MEM_WRITE) begin
        mcnt         = 0;
        MEM_BUSYWAIT = 1'b0;
      end else begin
        if ({MEM_READ, MEM_WRITE} != mprev) mcnt = 1;
        else mcnt++;
        MEM_BUSYWAIT = (mcnt < LMEM);
        if (MEM_READ) MEM_READDATA = mem[MEM_ADDRESS];
        if (MEM_WRITE && mcnt == LMEM) mem[MEM_ADDRESS] = MEM_WRITEDATA;
      end
      mprev = {MEM_READ, MEM_WRITE};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gold_blk(input logic [5:0] b);
    return {gold[{b, 2'd3}], gold[{b, 2'd2}], gold[{b, 2'd1}], gold[{b, 2'd0}]};
  endfunction

  // After a reset the cache is empty, so the visible memory is whatever was written back.
  task automatic model_reset();
    for (int b = 0; b < 64; b++)
      for (int o = 0; o < 4; o++) gold[b*4 + o] = mem[b][o*8 +: 8];
    for (int s = 0; s < 8; s++) begin
      m_vld[s] = 1'b0;
      m_dty[s] = 1'b0;
      m_tag[s] = '0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the request has completed.
  task automatic do_access(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [7:0] wd);
    logic [2:0]  t, ix;
    logic        exp_hit, exp_dirty, saw_wb, saw_rd, done;
    int          exp_stall, stall;
    logic [5:0]  vblk, wb_a, rd_a;
    logic [31:0] wb_d;
    logic [7:0]  rdata;
    t         = a[7:5];
    ix        = a[4:2];
    exp_hit   = m_vld[ix] && (m_tag[ix] == t);
    exp_dirty = !exp_hit && m_vld[ix] && m_dty[ix];
    exp_stall = exp_hit ? 0 : (exp_dirty ? 2 + 2*LMEM : 2 + LMEM);
    vblk      = {m_tag[ix], ix};
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    stall = 0; saw_wb = 0; saw_rd = 0; done = 0;
    wb_a = '0; rd_a = '0; wb_d = '0; rdata = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      chk("rw_excl", 32'(MEM_READ & MEM_WRITE), 32'd0);
      if (MEM_WRITE && !saw_wb) begin saw_wb = 1; wb_a = MEM_ADDRESS; wb_d = MEM_WRITEDATA; end
      if (MEM_READ && !saw_rd) begin saw_rd = 1; rd_a = MEM_ADDRESS; end
      if (BUSYWAIT) stall++;
      else begin done = 1; rdata = READDATA; end
    end
    chk("done", 32'(done), 32'd1);
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("wb_seen", 32'(saw_wb), 32'(exp_dirty));
    if (exp_dirty) begin
      chk("wb_addr", 32'(wb_a), 32'(vblk));
      chk("wb_data", wb_d, gold_blk(vblk));
    end
    chk("rd_seen", 32'(saw_rd), 32'(!exp_hit));
    if (!exp_hit) chk("rd_addr", 32'(rd_a), 32'({t, ix}));
    if (rd && !wr) chk("rdata", 32'(rdata), 32'(gold[a]));
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
    if (wr) gold[a] = wd;
    if (!exp_hit) begin
      m_vld[ix] = 1'b1;
      m_dty[ix] = 1'b0;
      m_tag[ix] = t;
    end
    if (wr) m_dty[ix] = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a request held so the stall gating is exercised.
    READ = 1'b1; ADDRESS = 8'h04;
    #12;
    chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
    chk("rst_mem_read", 32'(MEM_READ), 32'd0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    chk("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
    chk("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
    chk("rst_readdata", 32'(READDATA), 32'd0);
    READ = 1'b0;
    @(negedge CLK); #2 RESET = 1'b1;
    model_reset();
    @(posedge CLK); #1;

    // Clean miss, hit, write hit, dirty eviction.
    do_access(1, 0, 8'h04, 8'h00);
    do_access(1, 0, 8'h05, 8'h00);
    do_access(0, 1, 8'h06, 8'hAB);
    do_access(1, 0, 8'h06, 8'h00);
    do_access(0, 1, 8'h24, 8'h3C);
    chk("t4_mem_byte2", 32'(mem[1][23:16]), 32'h0000_00AB);
    do_access(1, 0, 8'h24, 8'h00);

    // Reset in the middle of a refill.
    READ = 1'b1; ADDRESS = 8'h08;
    repeat (3) @(negedge CLK);
    chk("t5_mem_read_pre", 32'(MEM_READ), 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("t5_mem_read", 32'(MEM_READ), 32'd0);
    chk("t5_busywait", 32'(BUSYWAIT), 32'd0);
    chk("t5_mem_addr", 32'(MEM_ADDRESS), 32'd0);
    #1 READ = 1'b0;
    @(negedge CLK); #2 RESET = 1'b1;
    model_reset();
    @(posedge CLK); #1;
    do_access(1, 0, 8'h04, 8'h00);

    // READ and WRITE together behave as a store.
    do_access(1, 1, 8'h05, 8'h5A);
    do_access(1, 0, 8'h05, 8'h00);
    do_access(1, 0, 8'h25, 8'h00);

    // Index wrap: 0xFF and 0x1F conflict in set 7.
    do_access(1, 0, 8'h1F, 8'h00);
    do_access(0, 1, 8'hFF, 8'h77);
    do_access(1, 0, 8'h1F, 8'h00);
    do_access(1, 0, 8'hFF, 8'h00);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int          op;
      logic [7:0]  a, d;
      op = $urandom_range(0, 4);
      a  = 8'($urandom);
      d  = 8'($urandom);
      case (op)
        0, 1:    do_access(1, 0, a, d);
        2, 3:    do_access(0, 1, a, d);
        default: do_access(1, 1, a, d);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
